spi_cmd_slave: RTL

- SPI slave command decoder inside top, on SYSCLK.
- It is the responder to the host SPI master: it oversamples SS/SCLK/MOSI, frames bytes and decodes the command stream.
- It drives the register bus (SD controller registers) and the block-data FIFO push/pop ports, and returns read data on MISO.
- SPI mode 0, MSB first; SCLK must be no faster than clk/8.

---
 rtl/spi_cmd_slave_if.sv | 45 ++++
 rtl/spi_cmd_slave.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_slave_if.sv
// Register bus and block-data FIFO ports driven by the SPI command slave.
// master: the command decoder; slave: the register file / FIFO side.
interface spi_cmd_slave_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic [7:0]        fifo_wdata;
    logic              fifo_we;
    logic              fifo_full;
    logic              fifo_re;
    logic [7:0]        fifo_rdata;
    logic              fifo_empty;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        input  reg_rdata,
        output fifo_wdata,
        output fifo_we,
        input  fifo_full,
        output fifo_re,
        input  fifo_rdata,
        input  fifo_empty
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        output reg_rdata,
        input  fifo_wdata,
        input  fifo_we,
        output fifo_full,
        input  fifo_re,
        output fifo_rdata,
        output fifo_empty
    );
endinterface

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 slave that oversamples the SPI pins on clk, frames bytes and
// turns the command stream into register-bus and FIFO push/pop strobes.
module spi_cmd_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter int         ADDR_W      = 7,
    parameter logic [7:0] CMD_REG     = 8'h89,
    parameter logic [7:0] CMD_FIFO_RD = 8'h8A,
    parameter logic [7:0] CMD_FIFO_WR = 8'h8B
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ss,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    spi_cmd_slave_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        REG_ADDR,
        REG_WDATA,
        REG_TAIL,
        REG_RDOUT,
        FRD_TURN,
        FRD_DATA,
        FWR_DATA
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] ss_q;
    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_prev;
    logic                   ss_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   rise;
    logic                   fall;

    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic [7:0] tx_shift;
    logic       byte_done;
    logic       ld_reg;
    logic       ld_fifo;

    logic addr_ld;
    logic wdata_ld;
    logic fwdata_ld;
    logic reg_we_nxt;
    logic reg_re_nxt;
    logic fifo_we_nxt;
    logic fifo_re_nxt;

    // ss synchronizer resets to "deselected" so nothing frames until the
    // real pin level has propagated through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_q      <= '1;
            sclk_q    <= '0;
            mosi_q    <= '0;
            sclk_prev <= 1'b0;
        end else begin
            ss_q      <= {ss_q[SYNC_STAGES-2:0], ss};
            sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
            mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
        end
    end

    assign ss_s      = ss_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign rise      = sclk_s & ~sclk_prev;
    assign fall      = ~sclk_s & sclk_prev;
    assign rx_byte   = {rx_shift, mosi_s};
    assign byte_done = ~ss_s & rise & (bit_cnt == 3'd7);
    assign miso      = tx_shift[7];

    always_ff @(posedge clk) begin
        if (!rst_n || ss_s) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
        end else if (rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= rx_byte[6:0];
        end
    end

    // Read data lands one clk after its strobe; ld_* mark that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || ss_s) begin
            tx_shift <= 8'h00;
            ld_reg   <= 1'b0;
            ld_fifo  <= 1'b0;
        end else begin
            ld_reg  <= bus.reg_re;
            ld_fifo <= bus.fifo_re;
            if (byte_done) begin
                tx_shift <= 8'h00;
            end else if (ld_reg) begin
                tx_shift <= bus.reg_rdata;
            end else if (ld_fifo) begin
                tx_shift <= bus.fifo_rdata;
            end else if (fall && bit_cnt != 3'd0) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_ld     = 1'b0;
        wdata_ld    = 1'b0;
        fwdata_ld   = 1'b0;
        reg_we_nxt  = 1'b0;
        reg_re_nxt  = 1'b0;
        fifo_we_nxt = 1'b0;
        fifo_re_nxt = 1'b0;
        if (ss_s) begin
            state_nxt = IDLE;
        end else if (byte_done) begin
            case (state)
                IDLE: begin
                    if (rx_byte == CMD_REG) begin
                        state_nxt = REG_ADDR;
                    end else if (rx_byte == CMD_FIFO_RD) begin
                        state_nxt = FRD_TURN;
                    end else if (rx_byte == CMD_FIFO_WR) begin
                        state_nxt = FWR_DATA;
                    end
                end
                REG_ADDR: begin
                    addr_ld = 1'b1;
                    if (rx_byte[7]) begin
                        state_nxt = REG_WDATA;
                    end else begin
                        reg_re_nxt = 1'b1;
                        state_nxt  = REG_RDOUT;
                    end
                end
                REG_WDATA: begin
                    wdata_ld   = 1'b1;
                    reg_we_nxt = 1'b1;
                    state_nxt  = REG_TAIL;
                end
                FRD_TURN: begin
                    fifo_re_nxt = ~bus.fifo_empty;
                    state_nxt   = FRD_DATA;
                end
                FWR_DATA: begin
                    fwdata_ld   = 1'b1;
                    fifo_we_nxt = ~bus.fifo_full;
                    state_nxt   = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.reg_addr   <= '0;
            bus.reg_wdata  <= 8'h00;
            bus.reg_we     <= 1'b0;
            bus.reg_re     <= 1'b0;
            bus.fifo_wdata <= 8'h00;
            bus.fifo_we    <= 1'b0;
            bus.fifo_re    <= 1'b0;
        end else begin
            bus.reg_we  <= reg_we_nxt;
            bus.reg_re  <= reg_re_nxt;
            bus.fifo_we <= fifo_we_nxt;
            bus.fifo_re <= fifo_re_nxt;
            if (addr_ld) begin
                bus.reg_addr <= rx_byte[ADDR_W-1:0];
            end
            if (wdata_ld) begin
                bus.reg_wdata <= rx_byte;
            end
            if (fwdata_ld) begin
                bus.fifo_wdata <= rx_byte;
            end
        end
    end

endmodule
